// File: rtl/jtag_pkg.sv
// Shared JTAG run-control types: command and hart-state encodings, capture signature, IR opcode.
package jtag_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_HALT   = 2'b01,
    CMD_STEP   = 2'b10,
    CMD_RESUME = 2'b11
  } run_cmd_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_STEP = 2'b10
  } hart_state_e;

  // Fixed LSB pattern loaded on Capture-DR so the host can verify scan-chain integrity.
  localparam logic [1:0] RC_CAPTURE_SIG = 2'b01;
  localparam logic [4:0] D_RUNCTRL      = 5'h11;

endpackage

// File: rtl/jtag_run_ctrl_if.sv
// TAP-side scan DR strobes and serial data; master is the TAP controller, slave is the data register.
interface jtag_run_ctrl_if;
  logic sel;
  logic capture_dr;
  logic shift_dr;
  logic update_dr;
  logic tdi;
  logic tdo;

  modport master (output sel, capture_dr, shift_dr, update_dr, tdi, input tdo);
  modport slave  (input sel, capture_dr, shift_dr, update_dr, tdi, output tdo);
endinterface

// File: rtl/hart_run_fsm.sv
// Per-hart RUN/HALT/STEP controller; clk_en/halted registered, updated on the edge sampling the cause.
// No backpressure: commands and halt requests are accepted on any tck edge.
module hart_run_fsm
  import jtag_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic              tck,
  input  logic              reset,
  input  logic              cmd_valid,
  input  run_cmd_e          cmd,
  input  logic [STEP_W-1:0] n,
  input  logic              ext_halt_req,
  output logic              clk_en,
  output logic              halted
);

  hart_state_e       state, state_nxt;
  logic [STEP_W-1:0] cnt, cnt_nxt;
  logic [STEP_W-1:0] step_load;
  logic              is_halt, is_step, is_resume;

  assign is_halt   = cmd_valid && (cmd == CMD_HALT);
  assign is_step   = cmd_valid && (cmd == CMD_STEP);
  assign is_resume = cmd_valid && (cmd == CMD_RESUME);
  assign step_load = (n == '0) ? STEP_W'(1) : n;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (is_halt || ext_halt_req) state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (ext_halt_req) begin
          state_nxt = ST_HALT;
        end else if (is_resume) begin
          state_nxt = ST_RUN;
        end else if (is_step) begin
          state_nxt = ST_STEP;
          cnt_nxt   = step_load;
        end
      end
      ST_STEP: begin
        if (is_halt || ext_halt_req) begin
          state_nxt = ST_HALT;
        end else if (is_resume) begin
          state_nxt = ST_RUN;
        end else if (is_step) begin
          cnt_nxt = step_load;
        end else if (cnt <= STEP_W'(1)) begin
          // Last enabled cycle: clk_en drops on this edge.
          state_nxt = ST_HALT;
        end else begin
          cnt_nxt = cnt - STEP_W'(1);
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      state  <= ST_RUN;
      cnt    <= '0;
      clk_en <= 1'b1;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      clk_en <= (state_nxt != ST_HALT);
      halted <= (state_nxt == ST_HALT);
    end
  end

endmodule

// File: rtl/jtag_run_ctrl.sv
// Run-control scan DR plus one hart FSM per hart; clk_en/halted follow update_dr by one tck.
// No backpressure: scan strobes are acted on every tck while sel is high.
module jtag_run_ctrl
  import jtag_pkg::*;
#(
  parameter int NUM_HARTS = 1,
  parameter int STEP_W    = 8
) (
  input  logic                 tck,
  input  logic                 reset,
  jtag_run_ctrl_if.slave       dr,
  input  logic [NUM_HARTS-1:0] ext_halt_req,
  output logic [NUM_HARTS-1:0] clk_en,
  output logic [NUM_HARTS-1:0] halted
);

  localparam int DR_LEN = NUM_HARTS + STEP_W + 2;

  logic [DR_LEN-1:0]    shreg;
  logic                 do_capture, do_shift, upd_vld;
  run_cmd_e             upd_cmd;
  logic [STEP_W-1:0]    upd_n;
  logic [NUM_HARTS-1:0] upd_mask;

  // Capture beats shift beats update when strobes overlap.
  assign do_capture = dr.sel && dr.capture_dr;
  assign do_shift   = dr.sel && dr.shift_dr && !dr.capture_dr;
  assign upd_vld    = dr.sel && dr.update_dr && !dr.capture_dr && !dr.shift_dr;

  assign upd_cmd  = run_cmd_e'(shreg[1:0]);
  assign upd_n    = shreg[2 +: STEP_W];
  assign upd_mask = shreg[DR_LEN-1 -: NUM_HARTS];
  assign dr.tdo   = shreg[0];

  always_ff @(posedge tck) begin
    if (reset) begin
      shreg <= '0;
    end else if (do_capture) begin
      shreg <= {halted, {STEP_W{1'b0}}, RC_CAPTURE_SIG};
    end else if (do_shift) begin
      shreg <= {dr.tdi, shreg[DR_LEN-1:1]};
    end
  end

  for (genvar i = 0; i < NUM_HARTS; i++) begin : g_hart
    hart_run_fsm #(.STEP_W(STEP_W)) u_hart (
      .tck          (tck),
      .reset        (reset),
      .cmd_valid    (upd_vld && upd_mask[i]),
      .cmd          (upd_cmd),
      .n            (upd_n),
      .ext_halt_req (ext_halt_req[i]),
      .clk_en       (clk_en[i]),
      .halted       (halted[i])
    );
  end

endmodule

// File: tb/tb_jtag_run_ctrl.sv
// Scoreboard bench for jtag_run_ctrl with two harts and an 8-bit step counter.
module tb_jtag_run_ctrl;

  localparam int NH     = 2;
  localparam int SW     = 8;
  localparam int DR_LEN = NH + SW + 2;

  logic          tck;
  logic          reset;
  logic [NH-1:0] ext_halt_req;
  logic [NH-1:0] clk_en;
  logic [NH-1:0] halted;

  jtag_run_ctrl_if dr_if ();

  jtag_run_ctrl #(.NUM_HARTS(NH), .STEP_W(SW)) dut (
    .tck          (tck),
    .reset        (reset),
    .dr           (dr_if),
    .ext_halt_req (ext_halt_req),
    .clk_en       (clk_en),
    .halted       (halted)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", obs, 32'hdead_beef);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic shift_bits(input logic sel_v, input logic [DR_LEN-1:0] din,
                            output logic [DR_LEN-1:0] dout);
    dr_if.sel      = sel_v;
    dr_if.shift_dr = 1'b1;
    for (int i = 0; i < DR_LEN; i++) begin
      dr_if.tdi = din[i];
      dout[i]   = dr_if.tdo;
      tick();
    end
    dr_if.shift_dr = 1'b0;
    dr_if.tdi      = 1'b0;
  endtask

  task automatic capture(input logic sel_v);
    dr_if.sel        = sel_v;
    dr_if.capture_dr = 1'b1;
    tick();
    dr_if.capture_dr = 1'b0;
  endtask

  task automatic update(input logic sel_v);
    dr_if.sel       = sel_v;
    dr_if.update_dr = 1'b1;
    tick();
    dr_if.update_dr = 1'b0;
  endtask

  task automatic scan_update(input logic [DR_LEN-1:0] v);
    logic [DR_LEN-1:0] dummy;
    shift_bits(1'b1, v, dummy);
    update(1'b1);
  endtask

  task automatic count_en0(output int c);
    c = 0;
    while (clk_en[0] && c < 300) begin
      c++;
      tick();
    end
  endtask

  // {mask[1:0], n[7:0], cmd[1:0]}
  function automatic logic [DR_LEN-1:0] dr_word(input logic [1:0] mask, input logic [7:0] n,
                                                 input logic [1:0] cmd);
    return {mask, n, cmd};
  endfunction

  logic [DR_LEN-1:0] sh_out;
  int                cyc;

  initial begin
    reset            = 1'b1;
    ext_halt_req     = '0;
    dr_if.sel        = 1'b0;
    dr_if.capture_dr = 1'b0;
    dr_if.shift_dr   = 1'b0;
    dr_if.update_dr  = 1'b0;
    dr_if.tdi        = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state, then the capture pattern shifted out LSB first.
    sb_push("reset_outs", {28'd0, 2'b11, 2'b00});
    sb_pop({28'd0, clk_en, halted});
    capture(1'b1);
    shift_bits(1'b1, '0, sh_out);
    sb_push("reset_capture", 32'h001);
    sb_pop({20'd0, sh_out});

    // HALT hart0 only.
    scan_update(dr_word(2'b01, 8'd0, 2'b01));
    sb_push("halt_h0", {28'd0, 2'b10, 2'b01});
    sb_pop({28'd0, clk_en, halted});

    // STEP 5, then STEP with n=0.
    scan_update(dr_word(2'b01, 8'd5, 2'b10));
    count_en0(cyc);
    sb_push("step5_cycles", 32'd5);
    sb_pop(cyc);
    sb_push("step5_done", {28'd0, 2'b10, 2'b01});
    sb_pop({28'd0, clk_en, halted});
    scan_update(dr_word(2'b01, 8'd0, 2'b10));
    count_en0(cyc);
    sb_push("step0_cycles", 32'd1);
    sb_pop(cyc);
    sb_push("step0_done", {28'd0, 2'b10, 2'b01});
    sb_pop({28'd0, clk_en, halted});

    // Long step aborted by a breakpoint, then status capture.
    scan_update(dr_word(2'b01, 8'd200, 2'b10));
    tick();
    tick();
    ext_halt_req = 2'b01;
    tick();
    ext_halt_req = 2'b00;
    sb_push("ext_abort", {28'd0, 2'b10, 2'b01});
    sb_pop({28'd0, clk_en, halted});
    capture(1'b1);
    shift_bits(1'b1, '0, sh_out);
    sb_push("status_capture", 32'h401);
    sb_pop({20'd0, sh_out});

    // RESUME, then RESUME colliding with a breakpoint.
    scan_update(dr_word(2'b01, 8'd0, 2'b11));
    sb_push("resume_h0", {28'd0, 2'b11, 2'b00});
    sb_pop({28'd0, clk_en, halted});
    shift_bits(1'b1, dr_word(2'b01, 8'd0, 2'b11), sh_out);
    ext_halt_req = 2'b01;
    update(1'b1);
    ext_halt_req = 2'b00;
    sb_push("resume_vs_ext", {28'd0, 2'b10, 2'b01});
    sb_pop({28'd0, clk_en, halted});

    // Reset in the middle of a long step must leave the hart free-running.
    scan_update(dr_word(2'b01, 8'd200, 2'b10));
    sb_push("step200_start", {28'd0, 2'b11, 2'b00});
    sb_pop({28'd0, clk_en, halted});
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_push("midstep_reset", {28'd0, 2'b11, 2'b00});
    sb_pop({28'd0, clk_en, halted});
    for (int i = 0; i < 210; i++) tick();
    sb_push("after_reset_run", {28'd0, 2'b11, 2'b00});
    sb_pop({28'd0, clk_en, halted});
    shift_bits(1'b1, '0, sh_out);
    sb_push("shreg_cleared", 32'h000);
    sb_pop({20'd0, sh_out});

    // Strobes with sel low must not disturb anything.
    shift_bits(1'b1, dr_word(2'b11, 8'd0, 2'b01), sh_out);
    capture(1'b0);
    shift_bits(1'b0, '1, sh_out);
    update(1'b0);
    sb_push("sel0_outs", {28'd0, 2'b11, 2'b00});
    sb_pop({28'd0, clk_en, halted});
    shift_bits(1'b1, '0, sh_out);
    sb_push("sel0_shreg", 32'hC01);
    sb_pop({20'd0, sh_out});

    // Halt both, then a zero-mask resume is a no-op.
    scan_update(dr_word(2'b11, 8'd0, 2'b01));
    sb_push("halt_both", {28'd0, 2'b00, 2'b11});
    sb_pop({28'd0, clk_en, halted});
    scan_update(dr_word(2'b00, 8'd0, 2'b11));
    sb_push("mask0_noop", {28'd0, 2'b00, 2'b11});
    sb_pop({28'd0, clk_en, halted});

    if (sb_q.size() != 0) check_val("scoreboard_leftover", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
